// File: rtl/axi4_lite_periph_bridge.sv
// Direct load/store-to-peripheral bridge: address decode, posted write FIFO, read FSM.
// Define AXI_PERIPH_TIMEOUT_EN to compile in the R_WAIT timeout counter.
module axi4_lite_periph_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLAVE_NUM      = 2,
  parameter int WBUF_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_BASE_ADDR =
    {32'h0000_1000, 32'h0000_0000},
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_ADDR_MASK =
    {32'hFFFF_F000, 32'hFFFF_F000}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             write_start,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic [DATA_WIDTH/8-1:0]          write_strobe,
  output logic                             write_busy,
  input  logic                             read_start,
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic                             read_busy,
  output logic                             read_valid,
  output logic                             error,
  output logic [1:0]                       error_code,
  output logic [SLAVE_NUM-1:0]             periph_mem_write,
  output logic [SLAVE_NUM*DATA_WIDTH/8-1:0] periph_byte_en,
  output logic [SLAVE_NUM*ADDR_WIDTH-1:0]  periph_write_addr,
  output logic [SLAVE_NUM*DATA_WIDTH-1:0]  periph_write_data,
  output logic [SLAVE_NUM*ADDR_WIDTH-1:0]  periph_read_addr,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0]  periph_read_data,
  input  logic [SLAVE_NUM-1:0]             periph_data_valid
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DRAIN,
    R_WAIT
  } r_state_t;

  // Returns {hit, index}; the downward scan leaves the lowest hit.
  function automatic logic [SW:0] decode(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [SW:0] r;
    r = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if ((a & SLAVE_ADDR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        r = {1'b1, SW'(i)};
      end
    end
    return r;
  endfunction

  r_state_t              state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SW-1:0]         r_sel;
  logic                  r_hit;

  logic [SW:0]           w_dec;
  logic [SW:0]           r_dec;
  logic                  w_hit;
  logic [SW-1:0]         w_sel;

  logic [SW-1:0]         fq_sel  [WBUF_DEPTH];
  logic [ADDR_WIDTH-1:0] fq_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] fq_data [WBUF_DEPTH];
  logic [BW-1:0]         fq_strb [WBUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;

  logic                  push;
  logic                  fifo_empty;
  logic                  can_drain;
  logic                  pop;
  logic                  bypass;
  logic                  store;
  logic                  timed_out;

  logic [SW-1:0]         d_sel;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_data;
  logic [BW-1:0]         d_strb;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  assign w_dec = decode(write_addr);
  assign r_dec = decode(read_addr);
  assign w_hit = w_dec[SW];
  assign w_sel = w_dec[SW-1:0];

  assign push       = write_start && !write_busy && w_hit;
  assign fifo_empty = (count == '0);
  assign can_drain  = (state != R_WAIT);
  assign pop        = !fifo_empty && can_drain;
  // An empty FIFO forwards the incoming write straight to the port.
  assign bypass     = fifo_empty && can_drain && push;
  assign store      = push && !bypass;
  assign count_nxt  = count + CW'(store) - CW'(pop);

  assign d_sel  = pop ? fq_sel[rd_ptr]  : w_sel;
  assign d_addr = pop ? fq_addr[rd_ptr] : write_addr;
  assign d_data = pop ? fq_data[rd_ptr] : write_data;
  assign d_strb = pop ? fq_strb[rd_ptr] : write_strobe;

  assign read_busy         = (state != R_IDLE);
  assign periph_write_addr = {SLAVE_NUM{wr_addr_q}};
  assign periph_write_data = {SLAVE_NUM{wr_data_q}};
  assign periph_read_addr  = {SLAVE_NUM{r_addr}};

`ifdef AXI_PERIPH_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != R_WAIT || periph_data_valid[r_sel]) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign timed_out = (state == R_WAIT) &&
                     !periph_data_valid[r_sel] &&
                     (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (store) begin
      fq_sel[wr_ptr]  <= w_sel;
      fq_addr[wr_ptr] <= write_addr;
      fq_data[wr_ptr] <= write_data;
      fq_strb[wr_ptr] <= write_strobe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= R_IDLE;
      r_addr           <= '0;
      r_sel            <= '0;
      r_hit            <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      write_busy       <= 1'b0;
      read_data        <= '0;
      read_valid       <= 1'b0;
      error            <= 1'b0;
      error_code       <= 2'b00;
      periph_mem_write <= '0;
      periph_byte_en   <= '0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count      <= count_nxt;
      write_busy <= (count_nxt == CW'(WBUF_DEPTH));

      periph_mem_write <= '0;
      periph_byte_en   <= '0;
      if (pop || bypass) begin
        periph_mem_write <= SLAVE_NUM'(1) << d_sel;
        periph_byte_en   <= {SLAVE_NUM{d_strb}};
        wr_addr_q        <= d_addr;
        wr_data_q        <= d_data;
      end

      error      <= 1'b0;
      read_valid <= 1'b0;
      if (write_start && !write_busy && !w_hit) begin
        error      <= 1'b1;
        error_code <= 2'b01;
      end

      unique case (state)
        R_IDLE: begin
          if (read_start) begin
            r_addr <= read_addr;
            r_sel  <= r_dec[SW-1:0];
            r_hit  <= r_dec[SW];
            if (!fifo_empty || push) begin
              state <= R_DRAIN;
            end else if (r_dec[SW]) begin
              state <= R_WAIT;
            end else begin
              read_data  <= '0;
              read_valid <= 1'b1;
              error      <= 1'b1;
              error_code <= 2'b10;
            end
          end
        end
        R_DRAIN: begin
          if (fifo_empty && !push) begin
            if (r_hit) begin
              state <= R_WAIT;
            end else begin
              state      <= R_IDLE;
              read_data  <= '0;
              read_valid <= 1'b1;
              error      <= 1'b1;
              error_code <= 2'b10;
            end
          end
        end
        R_WAIT: begin
          if (periph_data_valid[r_sel]) begin
            state      <= R_IDLE;
            read_data  <= periph_read_data[int'(r_sel)*DATA_WIDTH +: DATA_WIDTH];
            read_valid <= 1'b1;
          end else if (timed_out) begin
            state      <= R_IDLE;
            read_data  <= '0;
            read_valid <= 1'b1;
            error      <= 1'b1;
            error_code <= 2'b11;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_periph_bridge.sv
// Bench for axi4_lite_periph_bridge: scoreboard of expected writes/reads
// checked by a monitor, plus per-scenario timing checks.
module tb_axi4_lite_periph_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_start = 1'b0;
  logic [31:0] write_addr = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strobe = '0;
  logic        write_busy;
  logic        read_start = 1'b0;
  logic [31:0] read_addr = '0;
  logic [31:0] read_data;
  logic        read_busy;
  logic        read_valid;
  logic        error;
  logic [1:0]  error_code;
  logic [1:0]  periph_mem_write;
  logic [7:0]  periph_byte_en;
  logic [63:0] periph_write_addr;
  logic [63:0] periph_write_data;
  logic [63:0] periph_read_addr;
  logic [63:0] periph_read_data;
  logic [1:0]  periph_data_valid;
  logic [1:0]  dv_en = 2'b00;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wexp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  axi4_lite_periph_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .write_start       (write_start),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .write_strobe      (write_strobe),
    .write_busy        (write_busy),
    .read_start        (read_start),
    .read_addr         (read_addr),
    .read_data         (read_data),
    .read_busy         (read_busy),
    .read_valid        (read_valid),
    .error             (error),
    .error_code        (error_code),
    .periph_mem_write  (periph_mem_write),
    .periph_byte_en    (periph_byte_en),
    .periph_write_addr (periph_write_addr),
    .periph_write_data (periph_write_data),
    .periph_read_addr  (periph_read_addr),
    .periph_read_data  (periph_read_data),
    .periph_data_valid (periph_data_valid)
  );

  // Two small byte-addressable slave memories.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (periph_mem_write[0] && periph_byte_en[b])
          mem0[periph_write_addr[5:2]][8*b +: 8] <= periph_write_data[8*b +: 8];
        if (periph_mem_write[1] && periph_byte_en[4+b])
          mem1[periph_write_addr[37:34]][8*b +: 8] <= periph_write_data[32+8*b +: 8];
      end
    end
  end

  assign periph_read_data  = {mem1[periph_read_addr[37:34]],
                              mem0[periph_read_addr[5:2]]};
  assign periph_data_valid = dv_en;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    wexp_t we;
    rexp_t re;
    forever begin
      @(negedge clk);
      if (!rst && periph_mem_write != 2'b00) begin
        total++;
        if (wq.size() == 0) begin
          $display("FAIL wr_unexpected: got sel=%b addr=%h want no write",
                   periph_mem_write, periph_write_addr[31:0]);
        end else begin
          we = wq.pop_front();
          if (periph_mem_write !== we.sel ||
              periph_write_addr[31:0] !== we.addr ||
              periph_write_data[31:0] !== we.data ||
              periph_byte_en[3:0] !== we.be)
            $display("FAIL wr_content: got %b/%h/%h/%h want %b/%h/%h/%h",
                     periph_mem_write, periph_write_addr[31:0],
                     periph_write_data[31:0], periph_byte_en[3:0],
                     we.sel, we.addr, we.data, we.be);
          else passed++;
        end
      end
      if (!rst && read_valid) begin
        total++;
        if (rq.size() == 0) begin
          $display("FAIL rd_unexpected: got data=%h want no read_valid", read_data);
        end else begin
          re = rq.pop_front();
          if (read_data !== re.data || error !== re.err ||
              (re.err && error_code !== re.code))
            $display("FAIL rd_content: got %h/%b/%b want %h/%b/%b",
                     read_data, error, error_code, re.data, re.err, re.code);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    total++;
    if (write_busy !== 1'b0 || read_busy !== 1'b0 || read_valid !== 1'b0)
      $display("FAIL reset_busy: got wb=%b rb=%b rv=%b want 0/0/0",
               write_busy, read_busy, read_valid);
    else passed++;
    total++;
    if (error !== 1'b0 || error_code !== 2'b00)
      $display("FAIL reset_err: got %b/%b want 0/00", error, error_code);
    else passed++;
    total++;
    if (periph_mem_write !== 2'b00 || read_data !== 32'h0 || periph_byte_en !== 8'h0)
      $display("FAIL reset_out: got %b/%h/%h want 00/0/0",
               periph_mem_write, read_data, periph_byte_en);
    else passed++;
  endtask

  task automatic test_posted_write();
    write_start = 1'b1;
    write_addr = 32'h0000_0010;
    write_data = 32'hA5A5_1234;
    write_strobe = 4'hF;
    wq.push_back('{sel: 2'b01, addr: 32'h10, data: 32'hA5A5_1234, be: 4'hF});
    cyc();
    write_start = 1'b0;
    total++;
    if (periph_mem_write !== 2'b01 || periph_byte_en[3:0] !== 4'hF)
      $display("FAIL posted_timing: got %b/%h want 01/f",
               periph_mem_write, periph_byte_en[3:0]);
    else passed++;
    cyc();
    total++;
    if (periph_mem_write !== 2'b00)
      $display("FAIL posted_pulse: got %b want 00", periph_mem_write);
    else passed++;
  endtask

  task automatic test_read_basic();
    dv_en = 2'b11;
    read_start = 1'b1;
    read_addr = 32'h0000_0010;
    rq.push_back('{data: 32'hA5A5_1234, err: 1'b0, code: 2'b00});
    cyc();
    read_start = 1'b0;
    total++;
    if (read_busy !== 1'b1 || periph_read_addr[31:0] !== 32'h10 || read_valid !== 1'b0)
      $display("FAIL read_wait: got rb=%b ra=%h rv=%b want 1/10/0",
               read_busy, periph_read_addr[31:0], read_valid);
    else passed++;
    cyc();
    total++;
    if (read_valid !== 1'b1 || read_busy !== 1'b0)
      $display("FAIL read_timing: got rv=%b rb=%b want 1/0", read_valid, read_busy);
    else passed++;
    cyc();
  endtask

  task automatic test_raw();
    dv_en = 2'b11;
    write_start = 1'b1;
    write_addr = 32'h0000_1004;
    write_data = 32'hCAFE_F00D;
    write_strobe = 4'hF;
    read_start = 1'b1;
    read_addr = 32'h0000_1004;
    wq.push_back('{sel: 2'b10, addr: 32'h1004, data: 32'hCAFE_F00D, be: 4'hF});
    rq.push_back('{data: 32'hCAFE_F00D, err: 1'b0, code: 2'b00});
    cyc();
    write_start = 1'b0;
    read_start = 1'b0;
    total++;
    if (periph_mem_write !== 2'b10 || read_busy !== 1'b1)
      $display("FAIL raw_write_first: got %b/%b want 10/1", periph_mem_write, read_busy);
    else passed++;
    for (int i = 0; i < 10 && read_valid !== 1'b1; i++) cyc();
    total++;
    if (read_valid !== 1'b1)
      $display("FAIL raw_read_done: got %b want 1", read_valid);
    else passed++;
    cyc();
  endtask

  task automatic test_strobe();
    write_start = 1'b1;
    write_addr = 32'h0000_1008;
    write_data = 32'h1111_2222;
    write_strobe = 4'h3;
    wq.push_back('{sel: 2'b10, addr: 32'h1008, data: 32'h1111_2222, be: 4'h3});
    cyc();
    write_start = 1'b0;
    read_start = 1'b1;
    read_addr = 32'h0000_1008;
    rq.push_back('{data: 32'h0000_2222, err: 1'b0, code: 2'b00});
    cyc();
    read_start = 1'b0;
    for (int i = 0; i < 10 && read_valid !== 1'b1; i++) cyc();
    total++;
    if (read_valid !== 1'b1)
      $display("FAIL strobe_read_done: got %b want 1", read_valid);
    else passed++;
    cyc();
  endtask

  task automatic test_back_to_back();
    dv_en = 2'b11;
    read_start = 1'b1;
    read_addr = 32'h0000_0010;
    rq.push_back('{data: 32'hA5A5_1234, err: 1'b0, code: 2'b00});
    cyc();
    read_start = 1'b0;
    cyc();
    total++;
    if (read_valid !== 1'b1 || read_busy !== 1'b0)
      $display("FAIL b2b_first: got rv=%b rb=%b want 1/0", read_valid, read_busy);
    else passed++;
    read_start = 1'b1;
    read_addr = 32'h0000_1004;
    rq.push_back('{data: 32'hCAFE_F00D, err: 1'b0, code: 2'b00});
    cyc();
    read_start = 1'b0;
    total++;
    if (read_busy !== 1'b1 || read_valid !== 1'b0)
      $display("FAIL b2b_accept: got rb=%b rv=%b want 1/0", read_busy, read_valid);
    else passed++;
    cyc();
    total++;
    if (read_valid !== 1'b1)
      $display("FAIL b2b_second: got %b want 1", read_valid);
    else passed++;
    cyc();
  endtask

  task automatic test_decode_errors();
    write_start = 1'b1;
    write_addr = 32'h8000_0000;
    write_data = 32'hDEAD_BEEF;
    write_strobe = 4'hF;
    cyc();
    write_start = 1'b0;
    total++;
    if (error !== 1'b1 || error_code !== 2'b01 || periph_mem_write !== 2'b00)
      $display("FAIL wr_decode: got err=%b code=%b mw=%b want 1/01/00",
               error, error_code, periph_mem_write);
    else passed++;
    cyc();
    total++;
    if (error !== 1'b0 || error_code !== 2'b01)
      $display("FAIL err_pulse: got err=%b code=%b want 0/01", error, error_code);
    else passed++;
    read_start = 1'b1;
    read_addr = 32'h8000_0000;
    rq.push_back('{data: 32'h0, err: 1'b1, code: 2'b10});
    cyc();
    read_start = 1'b0;
    total++;
    if (read_valid !== 1'b1 || error !== 1'b1 || error_code !== 2'b10 || read_busy !== 1'b0)
      $display("FAIL rd_decode: got rv=%b err=%b code=%b rb=%b want 1/1/10/0",
               read_valid, error, error_code, read_busy);
    else passed++;
    cyc();
  endtask

  task automatic test_fifo_full();
    int pulses;
    pulses = 0;
    dv_en = 2'b00;
    read_start = 1'b1;
    read_addr = 32'h0000_0010;
    rq.push_back('{data: 32'hA5A5_1234, err: 1'b0, code: 2'b00});
    cyc();
    read_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      write_start = 1'b1;
      write_addr = 32'h0000_1020 + 32'(4 * k);
      write_data = 32'h0000_0100 + 32'(k);
      write_strobe = 4'hF;
      if (k < 4)
        wq.push_back('{sel: 2'b10, addr: 32'h1020 + 32'(4 * k),
                       data: 32'h100 + 32'(k), be: 4'hF});
      cyc();
      if (periph_mem_write != 2'b00) pulses++;
      if (k == 2) begin
        total++;
        if (write_busy !== 1'b0)
          $display("FAIL busy_early: got %b want 0", write_busy);
        else passed++;
      end
      if (k >= 3) begin
        total++;
        if (write_busy !== 1'b1)
          $display("FAIL busy_full: got %b want 1 after push %0d", write_busy, k + 1);
        else passed++;
      end
    end
    write_start = 1'b0;
    total++;
    if (pulses !== 0)
      $display("FAIL wait_no_drain: got %0d pulses want 0", pulses);
    else passed++;
    dv_en = 2'b01;
    cyc();
    total++;
    if (read_valid !== 1'b1)
      $display("FAIL full_read_done: got %b want 1", read_valid);
    else passed++;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (periph_mem_write != 2'b00) pulses++;
    end
    total++;
    if (pulses !== 4 || write_busy !== 1'b0)
      $display("FAIL full_drain: got %0d pulses wb=%b want 4/0", pulses, write_busy);
    else passed++;
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    dv_en = 2'b00;
    read_start = 1'b1;
    read_addr = 32'h0000_0010;
`ifdef AXI_PERIPH_TIMEOUT_EN
    rq.push_back('{data: 32'h0, err: 1'b1, code: 2'b11});
    cyc();
    read_start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      cyc();
      if (read_valid) early++;
    end
    cyc();
    total++;
    if (early !== 0 || read_valid !== 1'b1 || error !== 1'b1 || error_code !== 2'b11)
      $display("FAIL timeout: got early=%0d rv=%b err=%b code=%b want 0/1/1/11",
               early, read_valid, error, error_code);
    else passed++;
    cyc();
`else
    rq.push_back('{data: 32'hA5A5_1234, err: 1'b0, code: 2'b00});
    cyc();
    read_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (read_valid) early++;
    end
    total++;
    if (read_busy !== 1'b1 || early !== 0)
      $display("FAIL no_timeout: got rb=%b rv_count=%0d want 1/0", read_busy, early);
    else passed++;
    dv_en = 2'b01;
    for (int i = 0; i < 10 && read_valid !== 1'b1; i++) cyc();
    total++;
    if (read_valid !== 1'b1)
      $display("FAIL late_read_done: got %b want 1", read_valid);
    else passed++;
    cyc();
`endif
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    dv_en = 2'b00;
    read_start = 1'b1;
    read_addr = 32'h0000_0010;
    cyc();
    read_start = 1'b0;
    write_start = 1'b1;
    write_addr = 32'h0000_1040;
    write_data = 32'h5555_0001;
    write_strobe = 4'hF;
    cyc();
    write_addr = 32'h0000_1044;
    write_data = 32'h5555_0002;
    cyc();
    write_start = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if (read_busy !== 1'b0 || write_busy !== 1'b0 || error_code !== 2'b00)
      $display("FAIL mid_reset_state: got rb=%b wb=%b code=%b want 0/0/00",
               read_busy, write_busy, error_code);
    else passed++;
    dv_en = 2'b11;
    for (int i = 0; i < 10; i++) begin
      if (periph_mem_write != 2'b00 || read_valid) seen++;
      cyc();
    end
    total++;
    if (seen !== 0)
      $display("FAIL mid_reset_quiet: got %0d events want 0", seen);
    else passed++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_posted_write();
    test_read_basic();
    test_raw();
    test_strobe();
    test_back_to_back();
    test_decode_errors();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    total++;
    if (wq.size() !== 0 || rq.size() !== 0)
      $display("FAIL scoreboard_empty: got wq=%0d rq=%0d want 0/0", wq.size(), rq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi4_lite_periph_bridge.md
# axi4_lite_periph_bridge

Parametrised peripheral bridge that connects the core's start/busy load-store interface directly to SLAVE_NUM native peripheral ports (memories, timers, GPIO) without a full AXI4-Lite master/interconnect/slave chain. It decodes addresses against per-slave base/mask windows and buffers posted writes in a WBUF_DEPTH FIFO. Reads wait for a per-slave data_valid, with an optional timeout, and unmapped or timed-out accesses report through an error pulse.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- SLAVE_NUM, 2, number of peripheral ports (1..16)
- WBUF_DEPTH, 4, write-buffer entries; power of two, 2..16
- TIMEOUT_CYCLES, 16, read wait limit in cycles, 1..255
- SLAVE_BASE_ADDR, SLAVE_NUM x ADDR_WIDTH packed, window base per slave
- SLAVE_ADDR_MASK, SLAVE_NUM x ADDR_WIDTH packed; slave i hit when (addr & mask[i]) == base[i]
- clk  in  1  clock; one clock
- rst  in  1  reset; synchronous and active-high
- write_start  in  1  write request
- write_addr  in  ADDR_WIDTH  write address
- write_data  in  DATA_WIDTH  write data
- write_strobe  in  DATA_WIDTH/8  byte strobes
- write_busy  out  1  FIFO full
- read_start  in  1  read request
- read_addr  in  ADDR_WIDTH  read address
- read_data  out  DATA_WIDTH  last read result, held
- read_busy  out  1  read in progress
- read_valid  out  1  one-cycle pulse, read_data updated
- error  out  1  one-cycle error pulse
- error_code  out  2  01 write decode, 10 read decode, 11 read timeout; held until next error
- periph_mem_write  out  SLAVE_NUM  one-hot write pulse
- periph_byte_en  out  SLAVE_NUM x DATA_WIDTH/8  strobes, valid with mem_write
- periph_write_addr / periph_write_data  out  SLAVE_NUM x ADDR_WIDTH / DATA_WIDTH  broadcast to all slaves
- periph_read_addr  out  SLAVE_NUM x ADDR_WIDTH  broadcast read address
- periph_read_data  in  SLAVE_NUM x DATA_WIDTH  per-slave read data
- periph_data_valid  in  SLAVE_NUM  per-slave read data valid

## Operation
- Decode: lowest index wins on overlapping windows. No hit means unmapped.
- Write accept: write_start && !write_busy at an edge.
  - Mapped: push {slave, addr, data, strobe}.
  - Unmapped: no push; error pulses with code 01.
  - write_start while write_busy: ignored; no error.
- Drain: when the FIFO is non-empty and the read FSM is not in R_WAIT, pop the head. Drive periph_mem_write[slave] for exactly one cycle, with address, data and byte_en registered.
- Pointers wrap modulo WBUF_DEPTH. A push and a pop in the same cycle keep the count unchanged.
- Read FSM: R_IDLE -> R_DRAIN -> R_WAIT -> R_IDLE.
  - Accept: read_start && !read_busy captures the address.
  - R_DRAIN: holds until the FIFO is empty. This gives read-after-write ordering. It drains in 0 cycles if already empty.
  - Unmapped read: goes R_DRAIN -> R_IDLE, with read_data=0, read_valid, and error code 10.
  - R_WAIT: drives periph_read_addr. When periph_data_valid[slave] is sampled high, it captures periph_read_data[slave], pulses read_valid and returns to R_IDLE.
- read_busy = (state != R_IDLE).
- Simultaneous write_start and read_start: the write is pushed first, and the read waits until that write drains.
- Writes arriving during R_WAIT are buffered but not drained until the read completes.
- Reset: all outputs 0, FIFO empty, state R_IDLE, error_code 00.
  - Reset mid-operation discards buffered writes.
  - An in-flight read is abandoned with no read_valid.

## Timing
- Write pushed at edge N into an empty FIFO with the FSM idle: periph_mem_write is high during cycle N+1.
- Maximum drain rate is one write per cycle.
- Read accepted at edge N with the FIFO empty:
  - R_WAIT and periph_read_addr are valid from cycle N+1.
  - If data_valid is high in cycle N+1, read_valid and read_data appear in cycle N+2.
- read_busy is low in the read_valid cycle, so a back-to-back read_start can be accepted there.
- Unmapped read accepted at edge N with the FIFO empty: read_valid and error appear in cycle N+1.
- Timeout: TIMEOUT_CYCLES sampled cycles in R_WAIT without data_valid complete the read on the next cycle, with read_data=0 and error code 11.
- write_busy is registered. It rises in the cycle after the push that fills the FIFO.

## Configuration
- AXI_PERIPH_TIMEOUT_EN defined: an 8-bit wait counter is compiled in and timeout behaves as described.
- AXI_PERIPH_TIMEOUT_EN undefined: no counter; R_WAIT waits indefinitely and code 11 is never produced. TIMEOUT_CYCLES is ignored.

## Test plan
- Posted write: write 0x0000_0010 <- 0xA5A5_1234, strobe 0xF, slave 0 base 0x0 mask 0xFFFF_F000 -> periph_mem_write = 2'b01 for one cycle at N+1; byte_en 0xF; data 0xA5A5_1234.
- FIFO full: 5 writes on consecutive cycles with periph_data_valid held low and a read stalled in R_WAIT -> write_busy high after the 4th push; 5th write ignored; exactly 4 writes drain after the read completes.
- Read-after-write: write 0x1004 <- 0xCAFE_F00D, same-cycle read 0x1004 -> the periph_mem_write[1] pulse precedes R_WAIT; read_data = 0xCAFE_F00D.
- Decode errors: write 0x8000_0000 -> error with code 01 and no mem_write; read 0x8000_0000 -> read_valid, read_data 0, code 10.
- Timeout, TIMEOUT_CYCLES=16 with the macro defined: data_valid held low -> read_valid with read_data 0 and code 11 exactly 17 cycles after R_WAIT entry. With the macro undefined: read_busy is still high after 100 cycles.
- Reset mid-read with 2 writes buffered: rst for 1 cycle -> read_busy 0, no read_valid, FIFO empty, no further mem_write pulses.
